// File: rtl/matmul_axil_ctrl_v2.sv
// AXI4-Lite control/data front-end for the matrix-multiply engine: dimension and
// control registers, start/done handshake and a single shared A/B/C buffer port.
//
// write FSM state | meaning
//   W_IDLE        | waiting for awvalid and wvalid together
//   W_RESP        | bvalid held until bready
// read FSM state  | meaning
//   R_IDLE        | waiting for arvalid
//   R_DLY         | RDATA read lost the buffer port to a write; issue mem_re now
//   R_MEM         | buffer read in flight, capture mem_rdata
//   R_DATA        | rvalid held until rready
module matmul_axil_ctrl_v2 #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 8,
  parameter int MAX_M                = 8,
  parameter int MAX_K                = 8,
  parameter int MAX_N                = 8,
  parameter int MEM_ADDR_W           = 8,
  parameter int DIM_W                = 8
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic                                eng_start,
  input  logic                                eng_done,
  output logic [DIM_W-1:0]                    eng_m,
  output logic [DIM_W-1:0]                    eng_k,
  output logic [DIM_W-1:0]                    eng_n,
  output logic [1:0]                          mem_sel,
  output logic [MEM_ADDR_W-1:0]               mem_addr,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     mem_wdata,
  output logic                                mem_we,
  output logic                                mem_re,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     mem_rdata,
  output logic                                irq
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int RW = AW - 2;

  localparam logic [RW-1:0] A_CTRL   = RW'(0);
  localparam logic [RW-1:0] A_STATUS = RW'(1);
  localparam logic [RW-1:0] A_M      = RW'(2);
  localparam logic [RW-1:0] A_K      = RW'(3);
  localparam logic [RW-1:0] A_N      = RW'(4);
  localparam logic [RW-1:0] A_ADDR   = RW'(5);
  localparam logic [RW-1:0] A_WDATA  = RW'(6);
  localparam logic [RW-1:0] A_RDATA  = RW'(7);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DLY, R_MEM, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [1:0]            sel_q;
  logic                  auto_inc_q, irq_en_q;
  logic                  busy_q, done_q, err_q;
  logic [DIM_W-1:0]      m_q, k_q, n_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  start_q, irq_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DW-1:0]         rdata_q;

  logic [RW-1:0] wa, ra;
  logic          wr_acc, rd_acc;
  logic          wr_slverr, wr_mem, start_go, start_err;
  logic          mem_re_c;
  logic [DW-1:0] rd_mux;

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wa = s00_axi_awaddr[AW-1:2];
  assign ra = s00_axi_araddr[AW-1:2];

  function automatic logic dim_ok(input logic [DW-1:0] v, input int max_v);
    return (v != '0) && (v <= DW'(max_v));
  endfunction

  // Write FSM
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) w_state <= W_IDLE;
    else                w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    wr_acc = 1'b0;
    case (w_state)
      W_IDLE: if (s00_axi_awvalid && s00_axi_wvalid && !s00_axi_areset) begin
        wr_acc = 1'b1;
        w_next = W_RESP;
      end
      W_RESP: if (s00_axi_bready) w_next = W_IDLE;
    endcase
  end

  always_comb begin
    wr_slverr = 1'b0;
    wr_mem    = 1'b0;
    start_go  = 1'b0;
    start_err = 1'b0;
    if (wr_acc) begin
      case (wa)
        A_CTRL: begin
          start_go  = s00_axi_wdata[0] && !busy_q;
          start_err = s00_axi_wdata[0] && busy_q;
        end
        A_M:     wr_slverr = !dim_ok(s00_axi_wdata, MAX_M);
        A_K:     wr_slverr = !dim_ok(s00_axi_wdata, MAX_K);
        A_N:     wr_slverr = !dim_ok(s00_axi_wdata, MAX_N);
        A_WDATA: begin
          if (busy_q || sel_q == 2'd3) wr_slverr = 1'b1;
          else                         wr_mem    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read FSM
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) r_state <= R_IDLE;
    else                r_state <= r_next;
  end

  always_comb begin
    r_next   = r_state;
    rd_acc   = 1'b0;
    mem_re_c = 1'b0;
    case (r_state)
      R_IDLE: if (s00_axi_arvalid && !s00_axi_areset) begin
        rd_acc = 1'b1;
        if (ra == A_RDATA && !busy_q) begin
          // a same-cycle buffer write owns the port; the read goes next cycle
          if (wr_mem) r_next = R_DLY;
          else begin
            mem_re_c = 1'b1;
            r_next   = R_MEM;
          end
        end else begin
          r_next = R_DATA;
        end
      end
      R_DLY: begin
        mem_re_c = 1'b1;
        r_next   = R_MEM;
      end
      R_MEM:  r_next = R_DATA;
      R_DATA: if (s00_axi_rready) r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (ra)
      A_CTRL:   rd_mux = DW'({irq_en_q, auto_inc_q, sel_q, 2'b00});
      A_STATUS: rd_mux = DW'({err_q, busy_q, done_q, 1'b0});
      A_M:      rd_mux = DW'(m_q);
      A_K:      rd_mux = DW'(k_q);
      A_N:      rd_mux = DW'(n_q);
      A_ADDR:   rd_mux = DW'(addr_q);
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      sel_q      <= '0;
      auto_inc_q <= 1'b0;
      irq_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      m_q        <= DIM_W'(1);
      k_q        <= DIM_W'(1);
      n_q        <= DIM_W'(1);
      addr_q     <= '0;
      start_q    <= 1'b0;
      irq_q      <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      start_q <= start_go;
      irq_q   <= done_q & irq_en_q;

      if (wr_acc) begin
        bresp_q <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
        case (wa)
          A_CTRL: begin
            sel_q      <= s00_axi_wdata[3:2];
            auto_inc_q <= s00_axi_wdata[4];
            irq_en_q   <= s00_axi_wdata[5];
          end
          A_M: if (!wr_slverr) m_q <= s00_axi_wdata[DIM_W-1:0];
          A_K: if (!wr_slverr) k_q <= s00_axi_wdata[DIM_W-1:0];
          A_N: if (!wr_slverr) n_q <= s00_axi_wdata[DIM_W-1:0];
          default: ;
        endcase
      end

      if (wr_acc && wa == A_ADDR)
        addr_q <= s00_axi_wdata[MEM_ADDR_W-1:0];
      else if (auto_inc_q && (wr_mem || mem_re_c))
        addr_q <= addr_q + 1'b1;

      // eng_done must not be lost to a coincident clear
      if (eng_done)                                           done_q <= 1'b1;
      else if (start_go)                                      done_q <= 1'b0;
      else if (wr_acc && wa == A_STATUS && s00_axi_wdata[1])  done_q <= 1'b0;

      if (start_go)      busy_q <= 1'b1;
      else if (eng_done) busy_q <= 1'b0;

      if (wr_slverr || start_err)                             err_q <= 1'b1;
      else if (wr_acc && wa == A_STATUS && s00_axi_wdata[3])  err_q <= 1'b0;

      if (rd_acc) begin
        rdata_q <= rd_mux;
        rresp_q <= (ra == A_RDATA && busy_q) ? RESP_SLVERR : RESP_OKAY;
      end else if (r_state == R_MEM) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign s00_axi_awready = wr_acc;
  assign s00_axi_wready  = wr_acc;
  assign s00_axi_bvalid  = (w_state == W_RESP);
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = rd_acc;
  assign s00_axi_rvalid  = (r_state == R_DATA);
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;

  assign eng_start = start_q;
  assign eng_m     = m_q;
  assign eng_k     = k_q;
  assign eng_n     = n_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wr_mem ? s00_axi_wdata : '0;
  assign mem_we    = wr_mem;
  assign mem_re    = mem_re_c;
  assign irq       = irq_q;

endmodule

// File: tb/tb_matmul_axil_ctrl_v2.sv
// Directed bench for matmul_axil_ctrl_v2: register table, buffer streaming,
// port conflict, busy protection, done/irq and mid-read reset.
module tb_matmul_axil_ctrl_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        eng_start, eng_done = 1'b0;
  logic [7:0]  eng_m, eng_k, eng_n;
  logic [1:0]  mem_sel;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re, irq;

  matmul_axil_ctrl_v2 dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .eng_start(eng_start), .eng_done(eng_done),
    .eng_m(eng_m), .eng_k(eng_k), .eng_n(eng_n), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, last_aw_cyc = 0, start_cyc = 0;
  int start_count = 0, we_count = 0, re_count = 0, overlap = 0;
  logic [7:0] we_log[$];

  // simple BRAM model: one cycle read latency
  logic [31:0] mem [0:3][0:255];
  initial for (int s = 0; s < 4; s++) for (int a = 0; a < 256; a++) mem[s][a] = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_sel][mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_sel][mem_addr];
  end

  always @(negedge clk) begin
    if (eng_start) begin start_count <= start_count + 1; start_cyc <= cyc; end
    if (mem_we) begin we_count <= we_count + 1; we_log.push_back(mem_addr); end
    if (mem_re) re_count <= re_count + 1;
    if (mem_we && mem_re) overlap <= overlap + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // all tasks start and end at #1 after a rising edge
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
    bit ok = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; last_aw_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) chk($sformatf("aw_timeout@%0h", a), 0, 1);
    ok = 0; resp = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; resp = bresp; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (!ok) chk($sformatf("b_timeout@%0h", a), 0, 1);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    bit ok = 0;
    int acc = 0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; acc = cyc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (!ok) chk($sformatf("ar_timeout@%0h", a), 0, 1);
    ok = 0; d = 'x; resp = 2'bxx; lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; d = rdata; resp = rresp; lat = cyc - acc; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (!ok) chk($sformatf("r_timeout@%0h", a), 0, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit wr, logic [7:0] a, logic [31:0] d,
                              logic [1:0] r, logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.resp = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  logic [1:0]  r, r2;
  logic [31:0] d;
  int          lat, lat2, base_we, base_re, base_start;

  initial begin
    // register table: reset values, dims, range errors, W1C, unmapped, CTRL
    add(0, 8'h08, 0, 2'b00, 1);      add(0, 8'h0C, 0, 2'b00, 1);
    add(0, 8'h10, 0, 2'b00, 1);      add(0, 8'h14, 0, 2'b00, 0);
    add(0, 8'h00, 0, 2'b00, 0);      add(0, 8'h04, 0, 2'b00, 0);
    add(1, 8'h08, 4, 2'b00, 0);      add(1, 8'h0C, 4, 2'b00, 0);
    add(1, 8'h10, 4, 2'b00, 0);      add(0, 8'h08, 0, 2'b00, 4);
    add(0, 8'h0C, 0, 2'b00, 4);      add(0, 8'h10, 0, 2'b00, 4);
    add(1, 8'h08, 0, 2'b10, 0);      add(1, 8'h08, 9, 2'b10, 0);
    add(0, 8'h08, 0, 2'b00, 4);      add(0, 8'h04, 0, 2'b00, 8);
    add(1, 8'h04, 8, 2'b00, 0);      add(0, 8'h04, 0, 2'b00, 0);
    add(1, 8'h0C, 8, 2'b00, 0);      add(0, 8'h0C, 0, 2'b00, 8);
    add(1, 8'h40, 32'hDEAD, 2'b00, 0); add(0, 8'h40, 0, 2'b00, 0);
    add(1, 8'h00, 32'h3C, 2'b00, 0); add(0, 8'h00, 0, 2'b00, 32'h3C);
    add(1, 8'h18, 32'h77, 2'b10, 0); add(0, 8'h04, 0, 2'b00, 8);
    add(1, 8'h04, 8, 2'b00, 0);      add(0, 8'h18, 0, 2'b00, 0);
    add(1, 8'h00, 0, 2'b00, 0);      add(0, 8'h00, 0, 2'b00, 0);

    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp,
                             eng_start, mem_sel, mem_addr, mem_we, mem_re, irq}), 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_eng_dims", {8'h0, eng_m, eng_k, eng_n}, 32'h0001_0101);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, r);
        chk($sformatf("vec%0d_bresp", i), r, vecs[i].resp);
      end else begin
        axi_read(vecs[i].addr, d, r, lat);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
        chk($sformatf("vec%0d_rresp", i), r, vecs[i].resp);
        chk($sformatf("vec%0d_lat", i), lat, 1);
      end
    end
    chk("eng_dims", {8'h0, eng_m, eng_k, eng_n}, 32'h0004_0804);
    chk("no_we_in_table", we_count, 0);

    // identity matrix into buffer A with auto-increment
    axi_write(8'h00, 32'h10, r);
    axi_write(8'h14, 0, r);
    we_log.delete();
    for (int i = 0; i < 16; i++) begin
      axi_write(8'h18, (i / 4 == i % 4) ? 1 : 0, r);
      chk($sformatf("id_wr%0d_bresp", i), r, 0);
    end
    chk("id_we_count", we_log.size(), 16);
    foreach (we_log[i]) chk($sformatf("id_we_addr%0d", i), we_log[i], i);
    chk("id_mem_a5", mem[0][5], 1);
    chk("id_mem_a6", mem[0][6], 0);
    axi_read(8'h14, d, r, lat);
    chk("id_addr_after_wr", d, 16);
    axi_write(8'h14, 0, r);
    for (int i = 0; i < 16; i++) begin
      axi_read(8'h1C, d, r, lat);
      chk($sformatf("id_rd%0d_data", i), d, (i / 4 == i % 4) ? 1 : 0);
      chk($sformatf("id_rd%0d_lat", i), lat, 2);
    end
    axi_read(8'h14, d, r, lat);
    chk("id_addr_after_rd", d, 16);

    // address wrap
    axi_write(8'h14, 255, r);
    axi_write(8'h18, 32'hABCD, r);
    axi_read(8'h14, d, r, lat);
    chk("wrap_addr", d, 0);
    chk("wrap_mem", mem[0][255], 32'hABCD);

    // simultaneous WDATA write and RDATA read: write first, read one cycle later
    axi_write(8'h14, 4, r);
    fork
      axi_write(8'h18, 32'h55, r2);
      axi_read(8'h1C, d, r, lat2);
    join
    chk("conf_bresp", r2, 0);
    chk("conf_mem4", mem[0][4], 32'h55);
    chk("conf_rdata", d, 1);
    chk("conf_lat", lat2, 3);
    axi_read(8'h14, d, r, lat);
    chk("conf_addr", d, 6);

    // start, busy protection, done and irq
    base_start = start_count;
    axi_write(8'h00, 32'h21, r);
    chk("start_pulses", start_count - base_start, 1);
    chk("start_timing", start_cyc - last_aw_cyc, 1);
    axi_read(8'h04, d, r, lat);
    chk("busy_status", d, 32'h4);
    base_we = we_count; base_re = re_count;
    axi_write(8'h18, 32'h99, r);
    chk("busy_wr_bresp", r, 2'b10);
    chk("busy_no_we", we_count - base_we, 0);
    axi_read(8'h1C, d, r, lat);
    chk("busy_rd_rresp", r, 2'b10);
    chk("busy_rd_data", d, 0);
    chk("busy_no_re", re_count - base_re, 0);
    axi_write(8'h00, 32'h21, r);
    chk("restart_no_pulse", start_count - base_start, 1);
    axi_read(8'h04, d, r, lat);
    chk("restart_err", d, 32'hC);
    eng_done = 1'b1;
    @(posedge clk); #1; eng_done = 1'b0;
    @(negedge clk);
    chk("irq_delay", irq, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq_set", irq, 1);
    @(posedge clk); #1;
    axi_read(8'h04, d, r, lat);
    chk("done_status", d, 32'hA);
    axi_write(8'h04, 32'h2, r);
    @(negedge clk);
    chk("irq_cleared", irq, 0);
    @(posedge clk); #1;
    axi_read(8'h04, d, r, lat);
    chk("status_after_w1c", d, 32'h8);

    // reset in the middle of an RDATA read
    rready = 1'b0; araddr = 8'h1C; arvalid = 1'b1;
    @(negedge clk);
    chk("rst_rd_accept", arready, 1);
    @(posedge clk); #1; arvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rd_rvalid_pre", rvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp,
                           eng_start, mem_sel, mem_addr, mem_we, mem_re, irq}), 0);
    chk("rst_rdata", rdata, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rready = 1'b1;
    @(negedge clk);
    chk("rst_no_rvalid", rvalid, 0);
    @(posedge clk); #1;
    axi_read(8'h08, d, r, lat);
    chk("rst_m_reads_1", d, 1);
    chk("no_we_re_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
